// File: rtl/lsu_pkg.sv
// lsu_pkg: shared types and helpers for the load/store sequencer.
//   lsu_state_e     : controller state encoding
//   F3_*            : RV64 load/store funct3 codes
//   DWORD_BYTES     : width of one data memory word in bytes
//   size_bytes()    : access size in bytes for a funct3 (111 reports 8)
//   lane_low_mask() : lane bits that must be zero for natural alignment
//   is_misaligned() : alignment check; funct3 111 is always misaligned
package lsu_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RMW_RD,
        WRITE,
        RESP
    } lsu_state_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_D  = 3'b011;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [2:0] F3_WU = 3'b110;

    localparam int DWORD_BYTES = 8;

    function automatic logic [3:0] size_bytes(input logic [2:0] funct3);
        logic [3:0] sz;
        case (funct3)
            F3_B, F3_BU: sz = 4'd1;
            F3_H, F3_HU: sz = 4'd2;
            F3_W, F3_WU: sz = 4'd4;
            default:     sz = 4'd8;
        endcase
        return sz;
    endfunction

    function automatic logic [2:0] lane_low_mask(input logic [2:0] funct3);
        logic [3:0] sz;
        sz = size_bytes(funct3);
        return 3'(sz - 4'd1);
    endfunction

    function automatic logic is_misaligned(input logic [2:0] funct3,
                                           input logic [2:0] lane);
        return (funct3 == 3'b111) || ((lane & lane_low_mask(funct3)) != 3'b000);
    endfunction

endpackage

// File: rtl/lsu_lane_merge.sv
// lsu_lane_merge: combinational lane extraction and store merge.
// Ports:
//   dword    in  64  doubleword read from memory
//   lane     in  3   byte offset of the access within dword
//   funct3   in  3   access size / signedness
//   wdata    in  64  store data, right-aligned
//   load_val out 64  addressed lane, sign/zero-extended per funct3
//   merged   out 64  dword with the addressed lane replaced by wdata low bytes
module lsu_lane_merge
    import lsu_pkg::*;
(
    input  logic [63:0] dword,
    input  logic [2:0]  lane,
    input  logic [2:0]  funct3,
    input  logic [63:0] wdata,
    output logic [63:0] load_val,
    output logic [63:0] merged
);

    logic [5:0]  shamt;
    logic [63:0] shifted;
    logic [63:0] byte_mask;
    logic [63:0] lane_mask;

    assign shamt   = {lane, 3'b000};
    assign shifted = dword >> shamt;

    always_comb begin
        byte_mask = '1;
        case (size_bytes(funct3))
            4'd1:    byte_mask = 64'h0000_0000_0000_00FF;
            4'd2:    byte_mask = 64'h0000_0000_0000_FFFF;
            4'd4:    byte_mask = 64'h0000_0000_FFFF_FFFF;
            default: byte_mask = '1;
        endcase
    end

    always_comb begin
        load_val = shifted;
        case (funct3)
            F3_B:    load_val = {{56{shifted[7]}},  shifted[7:0]};
            F3_H:    load_val = {{48{shifted[15]}}, shifted[15:0]};
            F3_W:    load_val = {{32{shifted[31]}}, shifted[31:0]};
            F3_BU:   load_val = {56'b0, shifted[7:0]};
            F3_HU:   load_val = {48'b0, shifted[15:0]};
            F3_WU:   load_val = {32'b0, shifted[31:0]};
            default: load_val = shifted;
        endcase
    end

    assign lane_mask = byte_mask << shamt;
    assign merged    = (dword & ~lane_mask) | ((wdata << shamt) & lane_mask);

endmodule

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: single-outstanding RV64 load/store sequencer in front of an
// 8-byte-wide data memory (combinational read, posedge write).
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   req_valid/req_ready           request handshake
//   req_we, req_funct3            store flag, RV funct3
//   req_addr, req_wdata           byte address, right-aligned store data
//   resp_valid/resp_ready         response handshake
//   resp_rdata, resp_err          load result (0 for stores), misaligned flag
//   mem_read_en, mem_write_en     data memory enables (never both high)
//   mem_addr, mem_wdata           doubleword-aligned address, write data
//   mem_rdata                     data memory read data
// Build option: LSU_MISALIGN_CHECK_EN -- when defined, misaligned requests
// complete with resp_err=1 and no memory access; when undefined the lane is
// forced to natural alignment and resp_err is tied low.
//
// state  | meaning
// IDLE   | ready for a request
// LOAD   | reading the containing doubleword for a load
// RMW_RD | reading the doubleword to merge a sub-doubleword store into
// WRITE  | writing the merged (or full) doubleword
// RESP   | holding the response until resp_ready
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [63:0]       req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [63:0]       resp_rdata,
    output logic              resp_err,
    output logic              mem_read_en,
    output logic              mem_write_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [63:0]       mem_wdata,
    input  logic [63:0]       mem_rdata
);

    lsu_state_e        state_q, state_d;
    logic [ADDR_W-1:0] addr_q;
    logic [2:0]        lane_q;
    logic [2:0]        f3_q;
    logic              we_q;
    logic              err_q;
    logic [63:0]       wdata_q;
    logic [63:0]       dword_q;

    logic              accept;
    logic [2:0]        lane_in;
    logic              err_in;
    logic [63:0]       load_val;
    logic [63:0]       merged;

    assign accept = req_valid & req_ready;

`ifdef LSU_MISALIGN_CHECK_EN
    assign lane_in  = req_addr[2:0];
    assign err_in   = is_misaligned(req_funct3, req_addr[2:0]);
    assign resp_err = (state_q == RESP) & err_q;
`else
    assign lane_in  = req_addr[2:0] & ~lane_low_mask(req_funct3);
    assign err_in   = 1'b0;
    assign resp_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            lane_q  <= '0;
            f3_q    <= '0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            wdata_q <= '0;
            dword_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                addr_q  <= {req_addr[ADDR_W-1:3], 3'b000};
                lane_q  <= lane_in;
                f3_q    <= req_funct3;
                we_q    <= req_we;
                err_q   <= err_in;
                wdata_q <= req_wdata;
            end
            if ((state_q == LOAD) || (state_q == RMW_RD)) begin
                dword_q <= mem_rdata;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (err_in)                             state_d = RESP;
                    else if (!req_we)                       state_d = LOAD;
                    else if (size_bytes(req_funct3) == 4'd8) state_d = WRITE;
                    else                                    state_d = RMW_RD;
                end
            end
            LOAD:    state_d = RESP;
            RMW_RD:  state_d = WRITE;
            WRITE:   state_d = RESP;
            RESP:    if (resp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    lsu_lane_merge u_lane_merge (
        .dword    (dword_q),
        .lane     (lane_q),
        .funct3   (f3_q),
        .wdata    (wdata_q),
        .load_val (load_val),
        .merged   (merged)
    );

    // Enables are gated by rst so a reset landing on a WRITE cycle cannot
    // commit a partial operation at that edge.
    always_comb begin
        req_ready    = (state_q == IDLE);
        resp_valid   = (state_q == RESP);
        mem_read_en  = ((state_q == LOAD) || (state_q == RMW_RD)) && !rst;
        mem_write_en = (state_q == WRITE) && !rst;
        mem_addr     = addr_q;
        mem_wdata    = '0;
        if (state_q == WRITE) begin
            mem_wdata = (size_bytes(f3_q) == 4'd8) ? wdata_q : merged;
        end
        resp_rdata = '0;
        if ((state_q == RESP) && !we_q && !err_q) begin
            resp_rdata = load_val;
        end
    end

endmodule

// File: tb/tb_lsu_ctrl.sv
module tb_lsu_ctrl;

    localparam int ADDR_W = 12;
`ifdef LSU_MISALIGN_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic              clk;
    logic              rst;
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [2:0]        req_funct3;
    logic [ADDR_W-1:0] req_addr;
    logic [63:0]       req_wdata;
    logic              resp_valid;
    logic              resp_ready;
    logic [63:0]       resp_rdata;
    logic              resp_err;
    logic              mem_read_en;
    logic              mem_write_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [63:0]       mem_wdata;
    logic [63:0]       mem_rdata;

    lsu_ctrl #(.ADDR_W(ADDR_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_funct3   (req_funct3),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_rdata   (resp_rdata),
        .resp_err     (resp_err),
        .mem_read_en  (mem_read_en),
        .mem_write_en (mem_write_en),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata)
    );

    // data memory the DUT talks to, plus an independent reference image
    logic [63:0] mem     [0:511];
    logic [63:0] ref_mem [0:511];

    assign mem_rdata = mem[mem_addr[ADDR_W-1:3]];

    always @(posedge clk) begin
        if (mem_write_en && !mem_read_en) mem[mem_addr[ADDR_W-1:3]] <= mem_wdata;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int both_en = 0;

    always @(negedge clk) begin
        if (mem_read_en && mem_write_en) both_en++;
    end

    typedef struct {
        logic [63:0] rdata;
        logic        err;
        int          lat;
    } exp_t;

    exp_t exp_q[$];

    function automatic int nbytes(input logic [2:0] f3);
        case (f3[1:0])
            2'd0:    return 1;
            2'd1:    return 2;
            2'd2:    return 4;
            default: return 8;
        endcase
    endfunction

    function automatic bit model_err(input logic [2:0] f3, input logic [11:0] addr);
        int l;
        if (!CHK) return 1'b0;
        if (f3 == 3'b111) return 1'b1;
        l = int'(addr[2:0]);
        return (l % nbytes(f3)) != 0;
    endfunction

    function automatic int model_lane(input logic [2:0] f3, input logic [11:0] addr);
        int l;
        l = int'(addr[2:0]);
        if (CHK) return l;
        return l - (l % nbytes(f3));
    endfunction

    function automatic logic [63:0] model_load(input logic [2:0] f3, input logic [11:0] addr);
        logic [63:0] word;
        logic [63:0] val;
        int n;
        int l;
        word = ref_mem[addr[11:3]];
        n = nbytes(f3);
        l = model_lane(f3, addr);
        val = '0;
        for (int i = 0; i < n; i++) val[8*i +: 8] = word[8*(l+i) +: 8];
        if (!f3[2] && n < 8 && val[8*n-1]) begin
            for (int i = n; i < 8; i++) val[8*i +: 8] = 8'hFF;
        end
        return val;
    endfunction

    task automatic model_store(input logic [2:0] f3, input logic [11:0] addr,
                               input logic [63:0] wdata);
        logic [63:0] word;
        int n;
        int l;
        word = ref_mem[addr[11:3]];
        n = nbytes(f3);
        l = model_lane(f3, addr);
        for (int i = 0; i < n; i++) word[8*(l+i) +: 8] = wdata[8*i +: 8];
        ref_mem[addr[11:3]] = word;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [11:0] addr, input logic [63:0] val);
        mem[addr[11:3]]     = val;
        ref_mem[addr[11:3]] = val;
    endtask

    // Issue one request, scoreboard its expected response, then check it.
    task automatic do_req(input string name, input bit we, input logic [2:0] f3,
                          input logic [11:0] addr, input logic [63:0] wdata,
                          input bit use_exp, input logic [63:0] exp_rd, input int hold);
        exp_t e;
        exp_t x;
        int   w;
        int   lat;
        int   rd_n;
        int   wr_n;
        int   rd_first;
        int   wr_first;
        bit   err;
        logic [63:0] r0;

        err     = model_err(f3, addr);
        e.err   = err;
        e.rdata = (we || err) ? 64'd0 : (use_exp ? exp_rd : model_load(f3, addr));
        e.lat   = err ? 1 : ((!we || nbytes(f3) == 8) ? 2 : 3);

        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        req_valid  = 1'b1;
        w = 0;
        while (!req_ready && w < 20) begin
            tick();
            w++;
        end
        checks++;
        if (!req_ready) begin
            failures++;
            $display("FAIL %s accept timeout: req_ready=%b want 1", name, req_ready);
            req_valid = 1'b0;
            return;
        end
        tick();
        req_valid = 1'b0;
        exp_q.push_back(e);
        if (we && !err) model_store(f3, addr, wdata);

        if (!err) begin
            checks++;
            if (mem_addr !== {addr[11:3], 3'b000}) begin
                failures++;
                $display("FAIL %s mem_addr: got %h want %h", name, mem_addr, {addr[11:3], 3'b000});
            end
        end

        lat = 1; rd_n = 0; wr_n = 0; rd_first = -1; wr_first = -1;
        while (!resp_valid && lat < 20) begin
            if (mem_read_en)  begin rd_n++; if (rd_first < 0) rd_first = lat; end
            if (mem_write_en) begin wr_n++; if (wr_first < 0) wr_first = lat; end
            tick();
            lat++;
        end
        x = exp_q.pop_front();
        checks++;
        if (!resp_valid) begin
            failures++;
            $display("FAIL %s resp timeout: resp_valid=%b want 1", name, resp_valid);
            return;
        end

        if (hold > 0) begin
            r0 = resp_rdata;
            req_we = 1'b0; req_funct3 = 3'b011; req_addr = 12'h010; req_valid = 1'b1;
            for (int h = 0; h < hold; h++) begin
                tick();
                checks++;
                if (resp_valid !== 1'b1 || resp_rdata !== r0 || req_ready !== 1'b0) begin
                    failures++;
                    $display("FAIL %s hold%0d: valid=%b rdata=%h ready=%b want 1 %h 0",
                             name, h, resp_valid, resp_rdata, req_ready, r0);
                end
            end
        end

        checks++;
        if (resp_rdata !== x.rdata) begin
            failures++;
            $display("FAIL %s rdata: got %h want %h", name, resp_rdata, x.rdata);
        end
        checks++;
        if (resp_err !== x.err) begin
            failures++;
            $display("FAIL %s err: got %b want %b", name, resp_err, x.err);
        end
        checks++;
        if (lat !== x.lat) begin
            failures++;
            $display("FAIL %s latency: got %0d want %0d", name, lat, x.lat);
        end

        checks++;
        if (err) begin
            if (rd_n != 0 || wr_n != 0) begin
                failures++;
                $display("FAIL %s enables: rd=%0d wr=%0d want 0 0", name, rd_n, wr_n);
            end
        end else if (!we) begin
            if (rd_n != 1 || wr_n != 0) begin
                failures++;
                $display("FAIL %s enables: rd=%0d wr=%0d want 1 0", name, rd_n, wr_n);
            end
        end else if (nbytes(f3) == 8) begin
            if (rd_n != 0 || wr_n != 1) begin
                failures++;
                $display("FAIL %s enables: rd=%0d wr=%0d want 0 1", name, rd_n, wr_n);
            end
        end else begin
            if (rd_n != 1 || wr_n != 1 || rd_first >= wr_first) begin
                failures++;
                $display("FAIL %s rmw order: rd=%0d@%0d wr=%0d@%0d want 1 then 1",
                         name, rd_n, rd_first, wr_n, wr_first);
            end
        end

        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        req_valid  = 1'b0;
        checks++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
            failures++;
            $display("FAIL %s post-handshake: valid=%b ready=%b want 0 1", name, resp_valid, req_ready);
        end
        checks++;
        if (mem[addr[11:3]] !== ref_mem[addr[11:3]]) begin
            failures++;
            $display("FAIL %s memory: got %h want %h", name, mem[addr[11:3]], ref_mem[addr[11:3]]);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_err !== 1'b0 ||
            resp_rdata !== 64'd0 || mem_read_en !== 1'b0 || mem_write_en !== 1'b0 ||
            mem_addr !== 12'd0 || mem_wdata !== 64'd0) begin
            failures++;
            $display("FAIL reset: ready=%b valid=%b err=%b rdata=%h rd=%b wr=%b addr=%h wdata=%h want 1 0 0 0 0 0 0 0",
                     req_ready, resp_valid, resp_err, resp_rdata, mem_read_en, mem_write_en,
                     mem_addr, mem_wdata);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_dword();
        do_req("sd_010", 1'b1, 3'b011, 12'h010, 64'h1122334455667788, 1'b0, 64'd0, 0);
        do_req("ld_010", 1'b0, 3'b011, 12'h010, 64'd0, 1'b1, 64'h1122334455667788, 0);
    endtask

    task automatic test_rmw();
        preload(12'h010, 64'h1122334455667788);
        do_req("sb_013", 1'b1, 3'b000, 12'h013, 64'h00000000000000AB, 1'b0, 64'd0, 0);
        do_req("ld_rmw", 1'b0, 3'b011, 12'h010, 64'd0, 1'b1, 64'h11223344AB667788, 0);
        do_req("sh_016", 1'b1, 3'b001, 12'h016, 64'hFFFFFFFFFFFFBEEF, 1'b0, 64'd0, 0);
        do_req("ld_sh",  1'b0, 3'b011, 12'h010, 64'd0, 1'b1, 64'hBEEF3344AB667788, 0);
        checks++;
        if (both_en != 0) begin
            failures++;
            $display("FAIL mutex: both-enable cycles=%0d want 0", both_en);
        end
    endtask

    task automatic test_extend();
        preload(12'h020, 64'h00000000FFFF8000);
        do_req("lh",  1'b0, 3'b001, 12'h020, 64'd0, 1'b1, 64'hFFFFFFFFFFFF8000, 0);
        do_req("lhu", 1'b0, 3'b101, 12'h020, 64'd0, 1'b1, 64'h0000000000008000, 0);
        do_req("lw4", 1'b0, 3'b010, 12'h024, 64'd0, 1'b1, 64'h0000000000000000, 0);
        do_req("lwu", 1'b0, 3'b110, 12'h020, 64'd0, 1'b1, 64'h00000000FFFF8000, 0);
        do_req("lb1", 1'b0, 3'b000, 12'h021, 64'd0, 1'b1, 64'hFFFFFFFFFFFFFF80, 0);
        do_req("lbu", 1'b0, 3'b100, 12'h021, 64'd0, 1'b1, 64'h0000000000000080, 0);
    endtask

    task automatic test_misalign();
        if (CHK) begin
            do_req("lw_022", 1'b0, 3'b010, 12'h022, 64'd0, 1'b1, 64'd0, 0);
            do_req("sh_021", 1'b1, 3'b001, 12'h021, 64'h1234, 1'b0, 64'd0, 0);
        end else begin
            do_req("lw_022", 1'b0, 3'b010, 12'h022, 64'd0, 1'b1, 64'hFFFFFFFFFFFF8000, 0);
            do_req("sh_021", 1'b1, 3'b001, 12'h021, 64'h1234, 1'b0, 64'd0, 0);
        end
        checks++;
        if (mem[12'h020 >> 3] !== ref_mem[12'h020 >> 3]) begin
            failures++;
            $display("FAIL misalign mem: got %h want %h", mem[12'h020 >> 3], ref_mem[12'h020 >> 3]);
        end
    endtask

    task automatic test_hold();
        do_req("ld_hold", 1'b0, 3'b011, 12'h010, 64'd0, 1'b0, 64'd0, 5);
    endtask

    task automatic test_reset_mid();
        int w;
        int seen_resp;
        int seen_wr;
        preload(12'h030, 64'hDEADBEEFCAFEF00D);
        req_we = 1'b1; req_funct3 = 3'b000; req_addr = 12'h030; req_wdata = 64'h55;
        req_valid = 1'b1;
        w = 0;
        while (!req_ready && w < 20) begin tick(); w++; end
        tick();
        req_valid = 1'b0;
        checks++;
        if (mem_read_en !== 1'b1) begin
            failures++;
            $display("FAIL rstmid rmw_rd: mem_read_en=%b want 1", mem_read_en);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
            failures++;
            $display("FAIL rstmid after: ready=%b valid=%b want 1 0", req_ready, resp_valid);
        end
        seen_resp = 0; seen_wr = 0;
        for (int i = 0; i < 4; i++) begin
            if (resp_valid)   seen_resp++;
            if (mem_write_en) seen_wr++;
            tick();
        end
        checks++;
        if (seen_resp != 0 || seen_wr != 0) begin
            failures++;
            $display("FAIL rstmid activity: resp=%0d wr=%0d want 0 0", seen_resp, seen_wr);
        end
        checks++;
        if (mem[12'h030 >> 3] !== 64'hDEADBEEFCAFEF00D) begin
            failures++;
            $display("FAIL rstmid mem: got %h want %h", mem[12'h030 >> 3], 64'hDEADBEEFCAFEF00D);
        end
    endtask

    task automatic test_back_to_back();
        logic [11:0] a;
        logic [2:0]  f3;
        bit          we;
        logic [63:0] wd;
        for (int i = 0; i < 24; i++) begin
            a  = 12'h040 + 12'($urandom_range(0, 31));
            f3 = 3'($urandom_range(0, 7));
            we = 1'($urandom_range(0, 1));
            wd = {$urandom, $urandom};
            do_req("b2b", we, f3, a, wd, 1'b0, 64'd0, 0);
        end
        checks++;
        if (both_en != 0 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL b2b tail: both_en=%0d leftover=%0d want 0 0", both_en, exp_q.size());
        end
    endtask

    initial begin
        for (int i = 0; i < 512; i++) begin
            mem[i]     = 64'd0;
            ref_mem[i] = 64'd0;
        end
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b0;
        req_addr = '0; req_wdata = '0; resp_ready = 1'b0;

        test_reset();
        test_dword();
        test_rmw();
        test_extend();
        test_misalign();
        test_hold();
        test_reset_mid();
        test_back_to_back();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lsu_ctrl.md
Name: lsu_ctrl

Overview:
- Load/store sequencer between the pipeline's memory stage and the data memory unit.
- The data memory unit is a 64-bit, byte-addressed, 8-byte-wide memory with a combinational read and a posedge write.
- lsu_ctrl accepts one RV64 load/store at a time over a valid/ready handshake.
- Loads: reads the containing aligned doubleword, then extracts and extends the addressed lane.
- Sub-doubleword stores: read-modify-write. Doubleword stores: direct write.

Parameters:
- ADDR_W, 12, byte address width shared with the data memory unit.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- req_valid  input  1  request present
- req_ready  output  1  controller can accept a request
- req_we  input  1  1 = store, 0 = load
- req_funct3  input  3  RV funct3: 000 B, 001 H, 010 W, 011 D, 100 BU, 101 HU, 110 WU
- req_addr  input  ADDR_W  byte address
- req_wdata  input  64  store data, right-aligned
- resp_valid  output  1  response present
- resp_ready  input  1  consumer accepts response
- resp_rdata  output  64  load result, extended per funct3; 0 for stores
- resp_err  output  1  misaligned access, no memory effect
- mem_read_en  output  1  to data memory read_en
- mem_write_en  output  1  to data memory write_en
- mem_addr  output  ADDR_W  always 8-byte aligned (low 3 bits zero)
- mem_wdata  output  64  to data memory data_in
- mem_rdata  input  64  from data memory data_out (combinational)

Behaviour:
- Clock and reset: clk, rst; reset is synchronous and active-high.
- Reset values: state IDLE; req_ready=1; resp_valid=0; resp_err=0; resp_rdata=0; mem_read_en=0; mem_write_en=0; mem_addr=0; mem_wdata=0.
- Mutual exclusion: mem_read_en and mem_write_en are never high in the same cycle. The memory ignores both if both are high.
- Request capture: on req_valid & req_ready, the request is registered and req_ready drops.
  - req_ready=1 only in IDLE.
  - mem_addr = {req_addr[ADDR_W-1:3], 3'b000}.
  - lane = req_addr[2:0].
- States:
  - IDLE -> LOAD (load), RMW_RD (store with size B/H/W), WRITE (store D), or RESP (misaligned, resp_err=1).
  - LOAD: mem_read_en=1; capture mem_rdata at the clock edge; -> RESP.
  - RMW_RD: mem_read_en=1; capture mem_rdata into the merge register; -> WRITE.
  - WRITE: mem_write_en=1; mem_wdata = merged doubleword (D: req_wdata unmodified); -> RESP.
  - RESP: resp_valid=1 and outputs stable until resp_ready; on resp_valid & resp_ready -> IDLE.
- Latency from accept to resp_valid:
  - Load: 2 cycles.
  - Store D: 2 cycles.
  - Store B/H/W: 3 cycles.
  - Error: 1 cycle.
  - Back-to-back throughput: one request per (latency + 1) cycles minimum. No overlap of IDLE and RESP.
- Load extraction:
  - Bytes [lane .. lane+size-1] of the captured doubleword, little-endian.
  - B/H/W are sign-extended; BU/HU/WU are zero-extended; D is passed through.
- Store merge: only the addressed lane bytes are replaced from req_wdata low bytes; all other bytes are written back unchanged.
- Alignment: required lane % size == 0. funct3=111 is treated as misaligned.
- Reset mid-operation: return to IDLE next cycle; any in-flight write does not occur; the response is dropped.

Optional Feature:
- Macro: LSU_MISALIGN_CHECK_EN.
- Defined: misaligned requests complete via IDLE -> RESP with resp_err=1, resp_rdata=0, and no mem_read_en/mem_write_en.
- Undefined: resp_err is constant 0. The lane is forced to natural alignment (lane & ~(size-1)) and the access proceeds normally.

Decomposition:
- lsu_pkg:
  - state enum lsu_state_e {IDLE, LOAD, RMW_RD, WRITE, RESP}
  - funct3 localparams F3_B..F3_WU
  - DWORD_BYTES=8
  - function size_bytes(funct3)
- Sub-module lsu_lane_merge (combinational):
  - Inputs: doubleword, lane, funct3, store data.
  - Outputs: extracted/extended load value and merged store doubleword.

Test Plan:
- Store D 0x1122334455667788 at 0x010, then LD 0x010 -> resp_rdata=0x1122334455667788; mem_addr=0x010; 2-cycle latency each.
- Memory 0x010 = 0x1122334455667788; SB 0xAB at 0x013; LD 0x010 -> 0x11223344AB667788. Verify RMW_RD then WRITE, with no cycle where mem_read_en and mem_write_en are both 1.
- Memory 0x020 = 0x00000000_FFFF8000: LH 0x020 -> 0xFFFFFFFFFFFF8000; LHU 0x020 -> 0x0000000000008000; LW 0x024 -> 0x0000000000000000; LWU 0x020 -> 0x00000000FFFF8000.
- With LSU_MISALIGN_CHECK_EN defined: LW 0x022 -> resp_err=1 after 1 cycle, no memory enables asserted, memory unchanged. Without the macro: same request reads lane 0 of 0x020.
- Hold resp_ready=0 for 5 cycles during a load: resp_valid and resp_rdata stay stable, req_ready stays 0, and the next req_valid is not accepted until the cycle after the handshake.
- Assert rst in the WRITE-preceding RMW_RD cycle of SB 0x55 at 0x030: memory at 0x030 is unchanged, no response is issued, and req_ready=1 on the cycle after reset.
